ttl_quad_gate_tester: RTL and testbench

Synchronous stimulus sequencer and checker for one quad 2-input gate package: ttl_7400, ttl_7401, or any pin-compatible 2-input quad. It drives all four gates' A/B inputs through a fixed 8-vector program and samples the four Y outputs after a programmable settle time. It compares each sample against a parameterised truth table and reports per-gate pass/fail. It sits on the board-test side of the design, between a host start/status register and the gate package under test.

---
 rtl/ttl_quad_gate_tester.sv | 124 ++++++++++++
 tb/tb_ttl_quad_gate_tester.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ttl_quad_gate_tester.sv
// Stimulus sequencer and checker for a quad 2-input gate package: drives an
// 8-vector A/B program, samples Y after a settle time, reports per-gate results.
module ttl_gate_lane #(
  parameter int         GATE   = 0,
  parameter logic [3:0] EXPECT = 4'b0111
) (
  input  logic [2:0] cur_vec,
  input  logic [2:0] ld_vec,
  output logic       ld_a,
  output logic       ld_b,
  output logic       exp_y
);
  localparam logic [1:0] OFS = 2'(GATE);

  logic [1:0] ld_combo, cur_combo;

  // Upper half of the program staggers combos per gate to expose swapped/bridged Y.
  assign ld_combo  = ld_vec[2]  ? ld_vec[1:0]  + OFS : ld_vec[1:0];
  assign cur_combo = cur_vec[2] ? cur_vec[1:0] + OFS : cur_vec[1:0];
  assign ld_a      = ld_combo[1];
  assign ld_b      = ld_combo[0];
  assign exp_y     = EXPECT[cur_combo];
endmodule

module ttl_quad_gate_tester #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] EXPECT        = 4'b0111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] a,
  output logic [3:0] b,
  input  logic [3:0] y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_gate,
  output logic [3:0] fail_count,
  output logic [2:0] first_fail_vec
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state;
  logic [2:0] vec, ld_vec;
  logic [3:0] cnt;
  logic [3:0] ld_a, ld_b, exp_y, mism;

  assign ld_vec = (state == S_IDLE) ? 3'd0 : vec + 3'd1;
  assign mism   = y ^ exp_y;
  assign busy   = (state != S_IDLE);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    ttl_gate_lane #(.GATE(i), .EXPECT(EXPECT)) u_lane (
      .cur_vec (vec),
      .ld_vec  (ld_vec),
      .ld_a    (ld_a[i]),
      .ld_b    (ld_b[i]),
      .exp_y   (exp_y[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      vec            <= '0;
      cnt            <= '0;
      a              <= '0;
      b              <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_gate      <= '0;
      fail_count     <= '0;
      first_fail_vec <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          fail_gate      <= '0;
          fail_count     <= '0;
          first_fail_vec <= '0;
          pass           <= 1'b0;
          vec            <= '0;
          a              <= ld_a;
          b              <= ld_b;
          cnt            <= CNT_LOAD;
          state          <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt == '0) state <= S_CHECK;
          else           cnt   <= cnt - 4'd1;
        end
        S_CHECK: begin
          fail_gate <= fail_gate | mism;
          if (|mism) begin
            fail_count <= fail_count + 4'd1;
            if (fail_count == '0) first_fail_vec <= vec;
          end
          if (vec != 3'd7) begin
            vec   <= vec + 3'd1;
            a     <= ld_a;
            b     <= ld_b;
            cnt   <= CNT_LOAD;
            state <= S_SETTLE;
          end else begin
            // Fold in the last vector's mismatches so pass is valid alongside done.
            pass  <= ((fail_gate | mism) == '0);
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: begin
          a     <= '0;
          b     <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ttl_quad_gate_tester.sv
// Scoreboard bench: runs push expected results, a monitor pops them on done.
module tb_ttl_quad_gate_tester;
  logic       clk = 0, reset = 1;
  logic       start1 = 0, start2 = 0;
  logic [3:0] a1, b1, y1, a2, b2, y2;
  logic       busy1, done1, pass1, busy2, done2, pass2;
  logic [3:0] fg1, fc1, fg2, fc2;
  logic [2:0] ffv1, ffv2;
  int         mode = 0;
  int         cyc = 0;
  int         total = 0, bad = 0;

  typedef struct {
    int         inst;
    int         lat;
    int         scyc;
    logic       pass;
    logic [3:0] fg;
    logic [3:0] fc;
    logic [2:0] ffv;
  } exp_t;
  exp_t q[$];

  ttl_quad_gate_tester u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_gate(fg1),
    .fail_count(fc1), .first_fail_vec(ffv1));

  ttl_quad_gate_tester #(.SETTLE_CYCLES(1), .EXPECT(4'b1000)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .fail_gate(fg2),
    .fail_count(fc2), .first_fail_vec(ffv2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate package models: 0 good 7400, 1 Y3 stuck high, 2 Y1/Y2 swapped.
  always_comb begin
    y1 = ~(a1 & b1);
    if (mode == 1) y1[2] = 1'b1;
    if (mode == 2) y1[1:0] = {y1[0], y1[1]};
    y2 = a2 & b2;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done1 || done2) begin
        if (q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          if (e.inst == 1) begin
            check("done_inst", {31'd0, done1}, 1);
            check("pass", {31'd0, pass1}, {31'd0, e.pass});
            check("fail_gate", {28'd0, fg1}, {28'd0, e.fg});
            check("fail_count", {28'd0, fc1}, {28'd0, e.fc});
            check("first_fail_vec", {29'd0, ffv1}, {29'd0, e.ffv});
          end else begin
            check("done_inst", {31'd0, done2}, 1);
            check("pass2", {31'd0, pass2}, {31'd0, e.pass});
            check("fail_gate2", {28'd0, fg2}, {28'd0, e.fg});
          end
          check("latency", cyc - e.scyc, e.lat);
          @(negedge clk);
          check("done_pulse", {31'd0, done1 | done2}, 0);
          check("busy_after", {31'd0, busy1 | busy2}, 0);
          check("ab_idle", {a1, b1, a2, b2}, 0);
        end
      end
    end
  end

  task automatic launch(input int inst, input int md, input int lat, input logic p,
                        input logic [3:0] fg, input logic [3:0] fc, input logic [2:0] ffv,
                        input bit push);
    exp_t e;
    @(negedge clk);
    mode = md;
    if (inst == 1) start1 = 1; else start2 = 1;
    e.inst = inst; e.lat = lat; e.scyc = cyc + 1;
    e.pass = p; e.fg = fg; e.fc = fc; e.ffv = ffv;
    if (push) q.push_back(e);
    @(negedge clk);
    start1 = 0; start2 = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (q.size() != 0) begin check("timeout", 1, 0); q.delete(); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [3:0] ea[8] = '{4'h0, 4'h0, 4'hf, 4'hf, 4'hc, 4'h6, 4'h3, 4'h9};
    logic [3:0] eb[8] = '{4'h0, 4'hf, 4'h0, 4'hf, 4'ha, 4'h5, 4'ha, 4'h5};

    repeat (2) @(negedge clk);
    check("rst_busy", {30'd0, busy1, busy2}, 0);
    check("rst_ab", {a1, b1, a2, b2}, 0);
    check("rst_res", {pass1, fg1, fc1, ffv1, done1}, 0);
    reset = 0;

    // Golden 7400, with vector sequence check (we are at k=0 after start edge).
    launch(1, 0, 24, 1'b1, 4'b0000, 4'd0, 3'd0, 1);
    for (int k = 0; k < 24; k++) begin
      if (k % 3 == 0) begin
        check($sformatf("a_v%0d", k / 3), {28'd0, a1}, {28'd0, ea[k / 3]});
        check($sformatf("b_v%0d", k / 3), {28'd0, b1}, {28'd0, eb[k / 3]});
      end
      if (k < 23) @(negedge clk);
    end
    drain();

    launch(1, 1, 24, 1'b0, 4'b0100, 4'd2, 3'd3, 1);
    drain();

    launch(1, 2, 24, 1'b0, 4'b0011, 4'd2, 3'd6, 1);
    drain();

    launch(2, 0, 16, 1'b1, 4'b0000, 4'd0, 3'd0, 1);
    drain();

    // start re-pulsed mid-run must not restart
    launch(1, 0, 24, 1'b1, 4'b0000, 4'd0, 3'd0, 1);
    repeat (4) @(negedge clk);
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    drain();

    // reset during vector 4 of a faulty run
    launch(1, 1, 24, 1'b0, 4'b0100, 4'd2, 3'd3, 0);
    repeat (13) @(negedge clk);
    check("mid_fail_gate", {28'd0, fg1}, 4'b0100);
    check("mid_fail_count", {28'd0, fc1}, 1);
    reset = 1;
    @(negedge clk);
    check("mr_busy", {31'd0, busy1}, 0);
    check("mr_ab", {24'd0, a1, b1}, 0);
    check("mr_res", {pass1, fg1, fc1, ffv1, done1}, 0);
    reset = 0;
    repeat (30) @(negedge clk);
    check("mr_stays_idle", {31'd0, busy1}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
